encoded_tx_assembler: RTL and testbench
=======================================

// Module: encoded_tx_assembler
// PURPOSE
//  Byte-stream writer for the 6120-bit encoded_transaction bus consumed by zk_all.
//  Packs a 765-byte host stream into one frame, screens framing errors and fee > amount,
//  and presents the frame on a valid/ready output for the proving pipeline.
// PARAMETERS
//  TX_BYTES  765  bytes per frame; frame width W = TX_BYTES*8 (6120 at default)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   reset, synchronous, active-high
//  in_data     in   8   stream byte
//  in_valid    in   1   in_data valid
//  in_last     in   1   final byte of host frame; qualified by in_valid
//  in_ready    out  1   block accepts byte this cycle
//  tx_data     out  W   assembled encoded_transaction
//  tx_valid    out  1   tx_data/tx_fee_err valid
//  tx_ready    in   1   consumer accepts frame
//  tx_fee_err  out  1   fee (native) > amount (native) for the held frame
//  err_valid   out  1   one-cycle framing-error pulse
//  err_code    out  2   1=SHORT, 2=LONG, 0 otherwise
// BEHAVIOUR
//  - Reset: tx_valid=0, tx_fee_err=0, err_valid=0, err_code=0, tx_data=0, byte count=0, state=COLLECT.
//  - Byte transfer on in_valid & in_ready. Byte k (0-based) -> tx_data[W-1-8k -: 8]: first byte lands in [6119:6112], last in [7:0].
//  - States: COLLECT (in_ready=1), HOLD (in_ready=0), DRAIN (in_ready=1).
//  - COLLECT: count increments per transfer.
//    * k=TX_BYTES-1 with in_last: tx_data complete, tx_valid=1 next cycle (latency 1), -> HOLD.
//    * in_last at k<TX_BYTES-1: err_valid=1, err_code=SHORT next cycle; partial frame dropped; count=0; stay COLLECT.
//    * k=TX_BYTES-1 without in_last: err LONG pulse; frame dropped; -> DRAIN.
//  - DRAIN: discard bytes; transfer with in_last -> count=0, COLLECT. No further error pulses.
//  - HOLD: tx_data and tx_fee_err stable while tx_valid=1 & !tx_ready. On tx_valid & tx_ready: tx_valid=0
//    next cycle, -> COLLECT; first byte of next frame accepted no earlier than the following cycle.
//  - Fee screen: amount = LE uint64 in bytes 741..748 (tx_data[191:128]), fee = LE uint64 in bytes 733..740
//    (tx_data[255:192]); first byte of each field is least significant. tx_fee_err = (fee > amount),
//    unsigned 64-bit compare, registered with tx_valid. Frame still delivered; consumer decides.
//    Equal values -> 0 (amount - fee = 0 is legal).
//  - Transfers with in_valid=0 ignored; in_last without in_valid ignored.
//  - rst mid-frame or in HOLD: partial/held frame lost, no error pulse, outputs to reset values.
//  - err_valid never asserts in the cycle tx_valid rises (events are mutually exclusive by state).
// STRUCTURE
//  - Package zk_tx_pkg: TX_BYTES, TX_W, FEE_LSB_BYTE=733, AMOUNT_LSB_BYTE=741, ERR_NONE/SHORT/LONG,
//    state enum {COLLECT, HOLD, DRAIN}.
//  - Sub-module: reuse uint64_le_native_transform twice (amount, fee) before the comparator.
//  - Byte write uses count-decoded shift-in, not a W-bit barrel mux: shift tx_data left 8, insert at [7:0].
// TESTING
//  1 765 bytes, byte k = k mod 256, tx_ready=1 -> tx_valid 1 cycle after last; [6119:6112]=00, [7:0]=FC; err_valid never.
//  2 Same frame, tx_ready=0 for 10 cycles -> in_ready=0, tx_data stable 10 cycles; release -> tx_valid drops next cycle.
//  3 in_last on byte 100 -> err_code=1 pulse, no tx_valid; following clean frame delivered intact.
//  4 No in_last at byte 764, 5 extra bytes then in_last -> err_code=2 once, extras discarded, next frame clean.
//  5 amount=1000, fee=1001 (LE) -> tx_fee_err=1; fee=1000 -> 0; fee=0, amount=2^64-1 -> 0.
//  6 rst at byte 400, then 765-byte frame -> delivered frame equals second stream only, no error pulse.

Source files
------------

// File: rtl/zk_tx_pkg.sv
// zk_tx_pkg: shared frame geometry, error codes and assembler states
package zk_tx_pkg;
  localparam int TX_BYTES = 765;
  localparam int TX_W = TX_BYTES * 8;
  localparam int FEE_LSB_BYTE = 733;
  localparam int AMOUNT_LSB_BYTE = 741;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG = 2'd2;
  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;
endpackage

// File: rtl/uint64_le_native_transform.sv
// uint64_le_native_transform: little-endian byte field as laid out on the bus -> native uint64
module uint64_le_native_transform (
  input  logic [63:0] le_i,
  output logic [63:0] native_o
);
  // The field's first byte sits in the top lane of the slice and is the least significant.
  for (genvar b = 0; b < 8; b++) begin : g_swap
    assign native_o[8*b +: 8] = le_i[63-8*b -: 8];
  end
endmodule

// File: rtl/encoded_tx_assembler.sv
// encoded_tx_assembler: packs a host byte stream into one encoded_transaction frame with framing and fee screening
module encoded_tx_assembler
  import zk_tx_pkg::*;
#(
  parameter int TX_BYTES_P = TX_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [TX_BYTES_P*8-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_fee_err,
  output logic                    err_valid,
  output logic [1:0]              err_code
);
  localparam int W = TX_BYTES_P * 8;
  localparam int CW = $clog2(TX_BYTES_P);
  localparam int FEE_HI = W - 1 - 8 * FEE_LSB_BYTE;
  localparam int AMT_HI = W - 1 - 8 * AMOUNT_LSB_BYTE;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] data_q, data_d, shifted;
  logic tx_valid_q, tx_valid_d, fee_err_q, fee_err_d, err_valid_q, err_valid_d;
  logic [1:0] err_code_q, err_code_d;
  logic [63:0] fee, amount;
  logic xfer, full;
  assign in_ready = state_q != HOLD;
  assign xfer = in_valid & in_ready;
  assign full = cnt_q == CW'(TX_BYTES_P - 1);
  assign shifted = {data_q[W-9:0], in_data};
  assign tx_data = data_q;
  assign tx_valid = tx_valid_q;
  assign tx_fee_err = fee_err_q;
  assign err_valid = err_valid_q;
  assign err_code = err_code_q;
  // The screen looks at the frame as it will be once the incoming byte is shifted in.
  uint64_le_native_transform u_fee (.le_i(shifted[FEE_HI -: 64]), .native_o(fee));
  uint64_le_native_transform u_amount (.le_i(shifted[AMT_HI -: 64]), .native_o(amount));
  // Next-state: collect bytes, hand off a complete frame, or flag and drop a misframed one.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    tx_valid_d = tx_valid_q;
    fee_err_d = fee_err_q;
    err_valid_d = 1'b0;
    err_code_d = ERR_NONE;
    if (state_q == HOLD) begin
      if (tx_ready) begin
        tx_valid_d = 1'b0;
        fee_err_d = 1'b0;
        state_d = COLLECT;
      end
    end else if (xfer && state_q == DRAIN) begin
      state_d = in_last ? COLLECT : DRAIN;
    end else if (xfer) begin
      data_d = shifted;
      cnt_d = (in_last || full) ? '0 : cnt_q + CW'(1);
      if (full && in_last) begin
        state_d = HOLD;
        tx_valid_d = 1'b1;
        fee_err_d = fee > amount;
      end else if (in_last || full) begin
        err_valid_d = 1'b1;
        err_code_d = in_last ? ERR_SHORT : ERR_LONG;
        state_d = in_last ? COLLECT : DRAIN;
      end
    end
  end
  // State and output registers; reset discards any partial or held frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      data_q <= '0;
      tx_valid_q <= 1'b0;
      fee_err_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      tx_valid_q <= tx_valid_d;
      fee_err_q <= fee_err_d;
      err_valid_q <= err_valid_d;
      err_code_q <= err_code_d;
    end
  end
endmodule

// File: tb/tb_encoded_tx_assembler.sv
// tb_encoded_tx_assembler: randomized stream checks against a byte-array reference of each frame
module tb_encoded_tx_assembler;
  localparam int N = 765;
  localparam int W = N * 8;
  logic clk, rst, in_valid, in_last, in_ready, tx_valid, tx_ready, tx_fee_err, err_valid;
  logic [7:0] in_data;
  logic [1:0] err_code;
  logic [W-1:0] tx_data;
  logic [7:0] st [0:1023];
  int errors = 0, checks = 0;
  int n_short = 0, n_long = 0, n_bad = 0, n_rise = 0, n_overlap = 0;
  logic txv_prev = 1'b0;

  encoded_tx_assembler #(.TX_BYTES_P(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_fee_err(tx_fee_err), .err_valid(err_valid), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) txv_prev = 1'b0;
    else begin
      if (err_valid) begin
        if (err_code == 2'd1) n_short++;
        else if (err_code == 2'd2) n_long++;
        else n_bad++;
        if (tx_valid && !txv_prev) n_overlap++;
      end else if (err_code != 2'd0) n_bad++;
      if (tx_valid && !txv_prev) n_rise++;
      txv_prev = tx_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int g = 0;
    if ($urandom_range(3) == 0) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_data = b;
    in_valid = 1'b1;
    in_last = l;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) check("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_seq(input int len, input int last_idx);
    for (int i = 0; i < len; i++) send_byte(st[i], i == last_idx);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) st[i] = 8'($urandom);
  endtask

  task automatic expect_frame(input string tag);
    int g = 0;
    int bad = 0;
    logic [63:0] fee = '0, amt = '0;
    while (!tx_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_valid"}, tx_valid, 1);
    for (int k = 0; k < N; k++) if (tx_data[W-1-8*k -: 8] !== st[k]) bad++;
    check({tag, "_bad_bytes"}, bad, 0);
    check({tag, "_first"}, tx_data[W-1 -: 8], st[0]);
    check({tag, "_last"}, tx_data[7:0], st[N-1]);
    for (int i = 0; i < 8; i++) begin
      fee |= 64'(st[733+i]) << (8 * i);
      amt |= 64'(st[741+i]) << (8 * i);
    end
    check({tag, "_fee_err"}, tx_fee_err, fee > amt);
  endtask

  task automatic release_frame(input string tag);
    int g = 0;
    tx_ready = 1'b1;
    while (tx_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_released"}, tx_valid, 0);
  endtask

  task automatic fee_case(input logic [63:0] fee, input logic [63:0] amt, input logic exp);
    fill_random();
    for (int i = 0; i < 8; i++) begin
      st[733+i] = fee[8*i +: 8];
      st[741+i] = amt[8*i +: 8];
    end
    send_seq(N, N - 1);
    expect_frame("s5");
    check("s5_fee_const", tx_fee_err, exp);
    release_frame("s5");
  endtask

  initial begin
    int s_short, s_long, s_rise, chg, rdy, drop;
    logic [W-1:0] snap;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_fee_err", tx_fee_err, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_tx_data_or", |tx_data, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    // 1: ramp frame, consumer always ready
    for (int i = 0; i < 1024; i++) st[i] = 8'(i);
    s_short = n_short; s_long = n_long; s_rise = n_rise;
    send_seq(N, N - 1);
    check("s1_latency", tx_valid, 1);
    check("s1_top_byte", tx_data[W-1 -: 8], 8'h00);
    check("s1_low_byte", tx_data[7:0], 8'hFC);
    expect_frame("s1");
    release_frame("s1");
    check("s1_err_pulses", (n_short - s_short) + (n_long - s_long), 0);
    check("s1_one_rise", n_rise - s_rise, 1);
    // 2: same frame with back-pressure
    tx_ready = 1'b0;
    send_seq(N, N - 1);
    expect_frame("s2");
    snap = tx_data;
    chg = 0; rdy = 0; drop = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_data !== snap) chg++;
      if (in_ready !== 1'b0) rdy++;
      if (tx_valid !== 1'b1) drop++;
    end
    check("s2_data_stable", chg, 0);
    check("s2_in_ready_low", rdy, 0);
    check("s2_valid_held", drop, 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("s2_valid_drop", tx_valid, 0);
    check("s2_in_ready_back", in_ready, 1);
    // 3: short frame then clean frame
    fill_random();
    s_short = n_short; s_long = n_long; s_rise = n_rise;
    send_seq(101, 100);
    repeat (2) @(posedge clk);
    #1;
    check("s3_short_pulse", n_short - s_short, 1);
    check("s3_no_long", n_long - s_long, 0);
    check("s3_no_frame", n_rise - s_rise, 0);
    fill_random();
    send_seq(N, N - 1);
    expect_frame("s3");
    release_frame("s3");
    // 4: overlong frame, extras drained, then clean frame
    fill_random();
    s_short = n_short; s_long = n_long; s_rise = n_rise;
    send_seq(N + 5, N + 4);
    repeat (2) @(posedge clk);
    #1;
    check("s4_long_pulse", n_long - s_long, 1);
    check("s4_no_short", n_short - s_short, 0);
    check("s4_no_frame", n_rise - s_rise, 0);
    check("s4_in_ready", in_ready, 1);
    fill_random();
    send_seq(N, N - 1);
    expect_frame("s4");
    release_frame("s4");
    check("s4_long_once", n_long - s_long, 1);
    // 5: fee screen, fixed corners plus random pairs
    fee_case(64'd1001, 64'd1000, 1'b1);
    fee_case(64'd1000, 64'd1000, 1'b0);
    fee_case(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    fee_case(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    for (int r = 0; r < 2; r++) begin
      logic [63:0] f, a;
      f = {32'($urandom), 32'($urandom)};
      a = {32'($urandom), 32'($urandom)};
      fee_case(f, a, f > a);
    end
    // 6: reset mid-frame, then clean frame
    fill_random();
    send_seq(400, -1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s6_rst_tx_valid", tx_valid, 0);
    check("s6_rst_tx_data", |tx_data, 0);
    check("s6_rst_in_ready", in_ready, 1);
    rst = 1'b0;
    s_short = n_short; s_long = n_long;
    fill_random();
    send_seq(N, N - 1);
    expect_frame("s6");
    release_frame("s6");
    check("s6_no_err", (n_short - s_short) + (n_long - s_long), 0);
    check("bad_err_code", n_bad, 0);
    check("err_tx_overlap", n_overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
